decoder_5to32: RTL and testbench
================================

Name: decoder_5to32

Overview:
Registered binary-to-one-hot decoder: a 5-bit address A is sampled on the rising clock edge and drives a 32-bit one-hot word Z in which only bit A is set. It serves as the row/word-line select decoder in front of a 32-entry array and is the evaluation vehicle for decoder circuit studies. The output is registered so that downstream word-line drivers see glitch-free, cycle-aligned selects.

Parameters:
ADDR_WIDTH  5   width of address input A
OUT_WIDTH   32  width of one-hot output Z; must equal 2**ADDR_WIDTH (elaboration error otherwise)

Ports:
clk    input   1           clock; all state updates on rising edge
rst_n  input   1           asynchronous active-low reset
A      input   ADDR_WIDTH  binary select address
Z      output  OUT_WIDTH   registered one-hot decode of A

Behaviour:
- Reset: rst_n low asynchronously forces Z = 0 (all bits clear, no line selected), immediately and independent of clk. Z stays 0 while rst_n is low.
- Reset release: release is synchronised internally (two-flop deassert synchroniser on clk). Z remains 0 until the first rising edge after the synchroniser deasserts.
- Operation: on each rising edge of clk with reset inactive, Z <= (1 << A). Exactly one bit of Z is 1; that bit's index equals the A sampled at that edge.
- Latency: one cycle. A must be stable for setup time before the rising edge. The new Z is valid after clock-to-q and holds until the next rising edge.
- Structure: two-level predecode.
  - A[1:0] feeds a 2-to-4 predecoder; A[4:2] feeds a 3-to-8 predecoder. Both are combinational and one-hot.
  - Final stage: Z[i] = P0[i%4] AND P1[i/4], registered.
  - Parameterised implementations split ADDR_WIDTH into floor/ceil halves the same way.
- Boundary values:
  - A = 0 gives Z = 0x00000001.
  - A = 31 gives Z = 0x80000000.
  - Wrap from 31 to 0 between consecutive cycles: Z moves cleanly from bit 31 to bit 0 with no cycle of zero or multiple bits set.
- Repeated A: Z is unchanged; the register reloads the same value.
- X/Z on A: not a legal input. The design need not produce a defined output, but the bench flags it.
- Reset mid-operation: Z clears asynchronously within the same cycle. After release, decoding resumes with the current A.
- No other state, no enable, no handshake.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with A=7 -> Z=0x00000000 throughout. Release; after synchroniser delay plus 1 edge -> Z=0x00000080.
- Full sweep: drive A=0..31, one value per cycle, changing on the falling edge -> one cycle later Z==1<<A each time (0x00000001 ... 0x80000000). Check with case-inequality (no X allowed).
- Wrap and adjacency: sequence A=31,0,1,30 -> Z=0x80000000, 0x00000001, 0x00000002, 0x40000000. Check $countones(Z)==1 every cycle after the first post-reset edge.
- Hold: keep A=16 for 5 cycles -> Z=0x00010000 stable, with no toggling on any bit.
- Async reset mid-stream: assert rst_n=0 between edges while Z=0x00000400 -> Z=0 before the next edge, with no clock needed. Release with A=3 -> Z=0x00000008 after resync.
- Predecode cross-check: A=5'b10110 (22) -> Z=0x00400000. A=5'b01001 (9) -> Z=0x00000200. This exercises every predecoder output at least once across the sweep.

Source files
------------

// File: rtl/decoder_5to32.sv
// decoder_5to32: registered binary-to-one-hot word-line select decoder with two-level predecode
module decoder_5to32 #(
    parameter int ADDR_WIDTH = 5,
    parameter int OUT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] A,
    output logic [OUT_WIDTH-1:0]  Z
);
    localparam int LO   = ADDR_WIDTH / 2;
    localparam int HI   = ADDR_WIDTH - LO;
    localparam int P0_W = 1 << LO;
    localparam int P1_W = 1 << HI;

    if (OUT_WIDTH != (1 << ADDR_WIDTH)) begin : g_bad_width
        $error("decoder_5to32: OUT_WIDTH must equal 2**ADDR_WIDTH");
    end
    if (ADDR_WIDTH < 2) begin : g_bad_addr
        $error("decoder_5to32: ADDR_WIDTH must be at least 2 for two-level predecode");
    end

    logic [1:0]           rst_sync;
    logic [P0_W-1:0]      p0;
    logic [P1_W-1:0]      p1;
    logic [OUT_WIDTH-1:0] z_next;

    // Reset asserts immediately but releases only after two clean clk edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    // Low-half and high-half one-hot predecoders
    always_comb begin
        p0 = '0;
        p1 = '0;
        p0[A[LO-1:0]] = 1'b1;
        p1[A[ADDR_WIDTH-1:LO]] = 1'b1;
    end

    for (genvar i = 0; i < OUT_WIDTH; i++) begin : g_z
        assign z_next[i] = p0[i % P0_W] & p1[i / P0_W];
    end

    // Output register: cleared asynchronously, held clear until the synchroniser releases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            Z <= '0;
        else if (!rst_sync[1]) Z <= '0;
        else                   Z <= z_next;
    end
endmodule

// File: tb/tb_decoder_5to32.sv
// tb_decoder_5to32: randomized self-checking bench for the registered one-hot decoder
module tb_decoder_5to32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  A = 5'd7;
    logic [31:0] Z;
    int          n_tests = 0;
    int          n_fail = 0;

    decoder_5to32 dut (.clk(clk), .rst_n(rst_n), .A(A), .Z(Z));

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input int a);
        return 32'(64'(2) ** a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int a, input string tag);
        @(negedge clk);
        if ($isunknown(A)) check("a_unknown", 32'(A), 32'd0);
        A = 5'(a);
        @(posedge clk);
        #1;
        check(tag, Z, model(a));
        check({tag, "_onehot"}, 32'($countones(Z)), 32'd1);
    endtask

    task automatic release_and_check(input int a, input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check({tag, "_sync"}, Z, 32'd0);
        end
        @(posedge clk);
        #1;
        check(tag, Z, model(a));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("reset_hold", Z, 32'd0);
        end
        release_and_check(7, "reset_release");

        for (int a = 0; a < 32; a++) step(a, "sweep");

        step(31, "wrap31");
        step(0, "wrap0");
        step(1, "adj1");
        step(30, "adj30");

        for (int k = 0; k < 5; k++) step(16, "hold16");

        step(10, "pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", Z, 32'd0);
        A = 5'd3;
        @(posedge clk);
        #1;
        check("async_held", Z, 32'd0);
        release_and_check(3, "async_release");

        step(22, "predec22");
        step(9, "predec9");

        for (int k = 0; k < 200; k++) step(int'($urandom_range(31)), "random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
